oisc8_stack_unit: RTL and testbench

- Parametrised hardware LIFO for the OISC8 CPU; successor to the fixed RAM-backed stack inside the memory block.
- Holds top-of-stack (TOS) in a register and the remaining entries in a synchronous-read on-chip array. No external RAM cycles are used.
- Adds configurable width and depth, full/empty status, an occupancy count, sticky overflow/underflow flags, a push+pop replace operation and a ready handshake covering array refill.
- Sits behind the STACK/STACKR bus ports; the port logic drives push_en/pop_en.

---
 rtl/oisc8_stack_unit.sv | 155 +++++++++++++++
 tb/tb_oisc8_stack_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/oisc8_stack_unit.sv
// rtl/oisc8_stack_unit.sv - OISC8 LIFO: TOS register plus synchronous-read array.
// Optional high-water mark tracking enabled by defining OISC8_STACK_HWM_EN.
module oisc8_stack_unit #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_en,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop_en,
    output logic [DWIDTH-1:0] pop_data,
    output logic              ready,
    output logic              empty,
    output logic              full,
    output logic [CWIDTH-1:0] count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_flags,
    output logic [CWIDTH-1:0] hwm
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   tos_q, tos_d;
    logic [CWIDTH-1:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic [DWIDTH-1:0]   mem [DEPTH-1];
    logic [DWIDTH-1:0]   rd_data_q;
    logic                mem_we;
    logic                mem_re;
    logic [AW-1:0]       mem_wa;
    logic [AW-1:0]       mem_ra;
    logic                is_empty;
    logic                is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CWIDTH'(DEPTH));

    always_comb begin
        state_d     = state_q;
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~clr_flags;
        underflow_d = underflow_q & ~clr_flags;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wa      = AW'(count_q - CWIDTH'(1));
        mem_ra      = AW'(count_q - CWIDTH'(2));
        case (state_q)
            IDLE: begin
                if (push_en && pop_en) begin
                    // Replace: TOS swaps in place; on an empty stack it degrades to a push.
                    tos_d = push_data;
                    if (is_empty) begin
                        count_d     = CWIDTH'(1);
                        underflow_d = 1'b1;
                    end
                end else if (push_en) begin
                    if (is_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we  = !is_empty;
                        tos_d   = push_data;
                        count_d = count_q + CWIDTH'(1);
                    end
                end else if (pop_en) begin
                    if (is_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        count_d = count_q - CWIDTH'(1);
                        if (count_q > CWIDTH'(1)) begin
                            mem_re  = 1'b1;
                            state_d = REFILL;
                        end else begin
                            tos_d = '0;
                        end
                    end
                end
            end
            REFILL: begin
                tos_d   = rd_data_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Array contents survive reset; only the live region below count matters.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= tos_q;
        end
        if (mem_re) begin
            rd_data_q <= mem[mem_ra];
        end
    end

`ifdef OISC8_STACK_HWM_EN
    logic [CWIDTH-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

    assign pop_data  = (state_q == REFILL) ? rd_data_q : tos_q;
    assign ready     = (state_q == IDLE);
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_oisc8_stack_unit.sv
// tb/tb_oisc8_stack_unit.sv - Directed self-checking bench for oisc8_stack_unit (DWIDTH=8, DEPTH=4).
module tb_oisc8_stack_unit;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push_en;
    logic [DW-1:0] push_data;
    logic          pop_en;
    logic [DW-1:0] pop_data;
    logic          ready;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          clr_flags;
    logic [CW-1:0] hwm;

    int n_checks = 0;
    int n_fail   = 0;

    oisc8_stack_unit #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .push_en(push_en), .push_data(push_data),
        .pop_en(pop_en), .pop_data(pop_data), .ready(ready), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .underflow(underflow),
        .clr_flags(clr_flags), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_en   = 1'b0;
        pop_en    = 1'b0;
        clr_flags = 1'b0;
        push_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
        n_checks++; if (pop_data !== 8'h00) begin n_fail++; $display("FAIL reset_pop_data got %h exp 00", pop_data); end
        n_checks++; if (hwm !== 3'd0) begin n_fail++; $display("FAIL reset_hwm got %0d exp 0", hwm); end
    endtask

    task automatic test_push_full();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            push_en = 1'b1; push_data = vals[i];
            tick();
            n_checks++; if (pop_data !== vals[i]) begin n_fail++; $display("FAIL push_tos[%0d] got %h exp %h", i, pop_data, vals[i]); end
        end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL push_count got %0d exp 4", count); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL push_full got %b exp 1", full); end
        push_data = 8'h55;
        tick();
        push_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %b exp 1", overflow); end
        n_checks++; if (pop_data !== 8'h44) begin n_fail++; $display("FAIL overflow_tos got %h exp 44", pop_data); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL overflow_count got %0d exp 4", count); end
    endtask

    task automatic test_pop_drain();
        logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        pop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ready !== 1'b1 || pop_data !== exp[i]) begin n_fail++; $display("FAIL drain_pop[%0d] got ready=%b data=%h exp ready=1 data=%h", i, ready, pop_data, exp[i]); end
            tick();
            if (i < 3) begin
                n_checks++; if (ready !== 1'b0 || pop_data !== exp[i+1]) begin n_fail++; $display("FAIL drain_refill[%0d] got ready=%b data=%h exp ready=0 data=%h", i, ready, pop_data, exp[i+1]); end
                n_checks++; if (count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 3 - i); end
                tick();
            end
        end
        pop_en = 1'b0;
        n_checks++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty got empty=%b count=%0d exp 1,0", empty, count); end
        n_checks++; if (pop_data !== 8'h00 || underflow !== 1'b0) begin n_fail++; $display("FAIL drain_tail got data=%h uf=%b exp 00,0", pop_data, underflow); end
    endtask

    task automatic test_underflow();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got %b exp 0", overflow); end
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        n_checks++; if (underflow !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL underflow_set got uf=%b count=%0d exp 1,0", underflow, count); end
        clr_flags = 1'b1;
        tick();
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clr got %b exp 0", underflow); end
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_wins got %b exp 1", underflow); end
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic test_replace();
        push_en = 1'b1; push_data = 8'h11; tick();
        push_data = 8'h22; tick();
        pop_en = 1'b1; push_data = 8'h99; tick();
        push_en = 1'b0;
        n_checks++; if (pop_data !== 8'h99 || count !== 3'd2 || ready !== 1'b1) begin n_fail++; $display("FAIL replace got data=%h count=%0d ready=%b exp 99,2,1", pop_data, count, ready); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL replace_flag got %b exp 0", underflow); end
        tick();
        n_checks++; if (ready !== 1'b0 || pop_data !== 8'h11) begin n_fail++; $display("FAIL replace_refill got ready=%b data=%h exp 0,11", ready, pop_data); end
        tick();
        n_checks++; if (ready !== 1'b1 || pop_data !== 8'h11 || count !== 3'd1) begin n_fail++; $display("FAIL replace_pop2 got ready=%b data=%h count=%0d exp 1,11,1", ready, pop_data, count); end
        tick();
        pop_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL replace_empty got %b exp 1", empty); end
        push_en = 1'b1; pop_en = 1'b1; push_data = 8'h5A; tick();
        idle_inputs();
        n_checks++; if (count !== 3'd1 || pop_data !== 8'h5A || underflow !== 1'b1) begin n_fail++; $display("FAIL replace_empty_push got count=%0d data=%h uf=%b exp 1,5a,1", count, pop_data, underflow); end
    endtask

    task automatic test_reset_mid_refill();
        push_en = 1'b1; push_data = 8'hA1; tick();
        push_data = 8'hA2; tick();
        push_en = 1'b0; pop_en = 1'b1; tick();
        pop_en = 1'b0;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrefill_state got ready=%b exp 0", ready); end
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0 || ready !== 1'b1 || pop_data !== 8'h00 || hwm !== 3'd0) begin n_fail++; $display("FAIL async_reset got count=%0d ready=%b data=%h hwm=%0d exp 0,1,00,0", count, ready, pop_data, hwm); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_flag got %b exp 0", underflow); end
        tick();
        rst = 1'b0;
        push_en = 1'b1; push_data = 8'h7E; tick();
        push_en = 1'b0;
        n_checks++; if (pop_data !== 8'h7E || count !== 3'd1) begin n_fail++; $display("FAIL post_reset_push got data=%h count=%0d exp 7e,1", pop_data, count); end
    endtask

    task automatic test_hwm();
        logic [CW-1:0] exp_hwm;
`ifdef OISC8_STACK_HWM_EN
        exp_hwm = 3'd3;
`else
        exp_hwm = 3'd0;
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        push_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = 8'(8'hC0 + i); tick();
        end
        push_en = 1'b0; pop_en = 1'b1;
        tick(); tick(); tick(); tick();
        pop_en = 1'b0; push_en = 1'b1; push_data = 8'hD0; tick();
        push_en = 1'b0;
        n_checks++; if (count !== 3'd2 || pop_data !== 8'hD0) begin n_fail++; $display("FAIL hwm_seq got count=%0d data=%h exp 2,d0", count, pop_data); end
        n_checks++; if (hwm !== exp_hwm) begin n_fail++; $display("FAIL hwm got %0d exp %0d", hwm, exp_hwm); end
    endtask

    initial begin
        test_reset();
        test_push_full();
        test_pop_drain();
        test_underflow();
        test_replace();
        test_reset_mid_refill();
        test_hwm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
